// File: rtl/ddc_agc_ctrl_if.sv
// Sample, configuration and gain-control bundle of the DDC AGC loop controller.
// data_valid has no ready: a sample is consumed at the rising edge where data_valid=1 and the controller is accumulating, otherwise it is discarded.
interface ddc_agc_ctrl_if;
    logic               agc_en;
    logic               data_valid;
    logic signed [14:0] data_i;
    logic signed [14:0] data_q;
    logic [15:0]        target;
    logic [15:0]        hyst;
    logic [15:0]        step;
    logic [15:0]        clip_thr;
    logic [16:0]        man_value;
    logic [1:0]         man_sel;
    logic [16:0]        ddc_agc_value;
    logic [1:0]         ddc_agc_6db_sel;
    logic               update;
    logic               locked;
    logic               clip;
    logic [1:0]         fsm_state;

    modport master (
        output agc_en, data_valid, data_i, data_q, target, hyst, step, clip_thr, man_value, man_sel,
        input  ddc_agc_value, ddc_agc_6db_sel, update, locked, clip, fsm_state
    );

    modport slave (
        input  agc_en, data_valid, data_i, data_q, target, hyst, step, clip_thr, man_value, man_sel,
        output ddc_agc_value, ddc_agc_6db_sel, update, locked, clip, fsm_state
    );
endinterface

// File: rtl/ddc_agc_ctrl.sv
// Closed-loop AGC controller: averages |I|+|Q| over a window and steps the fine gain,
// spilling into the coarse 6 dB select when the fine gain leaves [GAIN_MIN, GAIN_MAX].
module ddc_agc_ctrl #(
    parameter int          WIN_LOG2 = 10,
    parameter int          SETTLE   = 8,
    parameter logic [16:0] GAIN_MIN = 17'h08000,
    parameter logic [16:0] GAIN_MAX = 17'h0FFFF
) (
    input logic           ddc_agc_ctrl_clk,
    input logic           ddc_agc_ctrl_rst_n,
    ddc_agc_ctrl_if.slave bus
);
    localparam int HW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, UPD = 2'd2, HOLD = 2'd3} state_t;

    state_t              state, state_nxt;
    logic [31:0]         acc;
    logic [WIN_LOG2-1:0] cnt;
    logic [WIN_LOG2:0]   clip_cnt;
    logic [HW-1:0]       hold_cnt;
    logic [2:0]          unch;
    logic [16:0]         m, m_nxt;
    logic [1:0]          sel, sel_nxt;
    logic                update, locked, clip;

    logic [14:0]        abs_i, abs_q;
    logic [15:0]        mag;
    logic               is_clip, last_sample;
    logic [15:0]        mean;
    logic [16:0]        hi, lo;
    logic               clip_hit, do_inc, do_dec, changed;
    logic [17:0]        sum_inc, dec_amt;
    logic signed [18:0] diff;
    logic [19:0]        dbl;

    // -16384 negates to 0x4000, which reads as +16384 when taken unsigned
    assign abs_i       = bus.data_i[14] ? 15'(-bus.data_i) : 15'(bus.data_i);
    assign abs_q       = bus.data_q[14] ? 15'(-bus.data_q) : 15'(bus.data_q);
    assign mag         = {1'b0, abs_i} + {1'b0, abs_q};
    assign is_clip     = (bus.data_i == 15'h3FFF) || (bus.data_i == 15'h4000) ||
                         (bus.data_q == 15'h3FFF) || (bus.data_q == 15'h4000);
    assign last_sample = bus.data_valid && (cnt == '1);

    assign mean     = acc[WIN_LOG2 +: 16];
    assign hi       = {1'b0, bus.target} + {1'b0, bus.hyst};
    assign lo       = (bus.target >= bus.hyst) ? {1'b0, bus.target - bus.hyst} : 17'd0;
    assign clip_hit = 17'(clip_cnt) >= {1'b0, bus.clip_thr};
    assign do_dec   = clip_hit || ({1'b0, mean} > hi);
    assign do_inc   = !clip_hit && ({1'b0, mean} < lo);
    assign sum_inc  = {1'b0, m} + {2'b00, bus.step};
    assign dec_amt  = clip_hit ? {bus.step, 2'b00} : {2'b00, bus.step};
    assign diff     = $signed({2'b00, m}) - $signed({1'b0, dec_amt});
    assign dbl      = diff[18] ? 20'd0 : {1'b0, diff[17:0], 1'b0};

    always_comb begin
        m_nxt   = m;
        sel_nxt = sel;
        if (do_dec) begin
            if (diff < $signed({2'b00, GAIN_MIN})) begin
                if (sel != 2'd0) begin
                    sel_nxt = sel - 2'd1;
                    if (dbl < {3'b000, GAIN_MIN})      m_nxt = GAIN_MIN;
                    else if (dbl > {3'b000, GAIN_MAX}) m_nxt = GAIN_MAX;
                    else                               m_nxt = dbl[16:0];
                end else begin
                    m_nxt = GAIN_MIN;
                end
            end else begin
                m_nxt = diff[16:0];
            end
        end else if (do_inc) begin
            if (sum_inc > {1'b0, GAIN_MAX}) begin
                if (sel != 2'd3) begin
                    sel_nxt = sel + 2'd1;
                    m_nxt   = sum_inc[17:1];
                end else begin
                    m_nxt = GAIN_MAX;
                end
            end else begin
                m_nxt = sum_inc[16:0];
            end
        end
    end

    assign changed = (m_nxt != m) || (sel_nxt != sel);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.agc_en) state_nxt = ACC;
            ACC:  if (last_sample) state_nxt = UPD;
            UPD:  state_nxt = changed ? HOLD : ACC;
            HOLD: if (hold_cnt == HW'(SETTLE - 1)) state_nxt = ACC;
        endcase
        if (!bus.agc_en) state_nxt = IDLE;
    end

    always_ff @(posedge ddc_agc_ctrl_clk) begin
        if (!ddc_agc_ctrl_rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            clip_cnt <= '0;
            hold_cnt <= '0;
            unch     <= '0;
            m        <= 17'h08000;
            sel      <= 2'd0;
            update   <= 1'b0;
            locked   <= 1'b0;
            clip     <= 1'b0;
        end else begin
            state  <= state_nxt;
            update <= 1'b0;
            if (!bus.agc_en && state != IDLE) begin
                // loop dropped mid-flight: forget the partial window, keep the gain until IDLE reloads it
                acc      <= '0;
                cnt      <= '0;
                clip_cnt <= '0;
                hold_cnt <= '0;
                unch     <= '0;
                locked   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        acc      <= '0;
                        cnt      <= '0;
                        clip_cnt <= '0;
                        hold_cnt <= '0;
                        unch     <= '0;
                        locked   <= 1'b0;
                        clip     <= 1'b0;
                        m        <= bus.man_value;
                        sel      <= bus.man_sel;
                    end
                    ACC: begin
                        if (bus.data_valid) begin
                            acc <= acc + {16'd0, mag};
                            cnt <= cnt + WIN_LOG2'(1);
                            if (is_clip) clip_cnt <= clip_cnt + (WIN_LOG2 + 1)'(1);
                        end
                    end
                    UPD: begin
                        m        <= m_nxt;
                        sel      <= sel_nxt;
                        update   <= changed;
                        clip     <= clip_hit;
                        acc      <= '0;
                        cnt      <= '0;
                        clip_cnt <= '0;
                        hold_cnt <= '0;
                        if (changed) begin
                            unch   <= '0;
                            locked <= 1'b0;
                        end else begin
                            if (unch != 3'd4) unch <= unch + 3'd1;
                            locked <= (unch >= 3'd3);
                        end
                    end
                    HOLD: begin
                        hold_cnt <= hold_cnt + HW'(1);
                        if (state_nxt == ACC) begin
                            acc      <= '0;
                            cnt      <= '0;
                            clip_cnt <= '0;
                            hold_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.ddc_agc_value   = m;
    assign bus.ddc_agc_6db_sel = sel;
    assign bus.update          = update;
    assign bus.locked          = locked;
    assign bus.clip            = clip;
    assign bus.fsm_state       = state;
endmodule

// File: tb/tb_ddc_agc_ctrl.sv
// Bench for ddc_agc_ctrl with a 16-sample window and an 8-clock settle time.
// A reference gain model queues the expected outcome of each window; the result is checked the cycle after the window closes.
module tb_ddc_agc_ctrl;
    localparam int WIN  = 16;
    localparam int GMIN = 'h8000;
    localparam int GMAX = 'hFFFF;
    localparam logic [1:0] S_IDLE = 2'd0, S_ACC = 2'd1, S_HOLD = 2'd3;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ddc_agc_ctrl_if bus();

    ddc_agc_ctrl #(.WIN_LOG2(4), .SETTLE(8)) dut (
        .ddc_agc_ctrl_clk  (clk),
        .ddc_agc_ctrl_rst_n(rst_n),
        .bus               (bus)
    );

    int errors = 0;
    int checks = 0;
    // {locked, clip, update, sel[1:0], value[16:0]}
    logic [21:0] exp_q[$];
    int mdl_m, mdl_sel, mdl_unch;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int tgt, input int h, input int s, input int ct);
        bus.target   = 16'(tgt);
        bus.hyst     = 16'(h);
        bus.step     = 16'(s);
        bus.clip_thr = 16'(ct);
    endtask

    task automatic enable_loop(input int man, input int sel);
        bus.agc_en     = 1'b0;
        bus.data_valid = 1'b0;
        bus.man_value  = 17'(man);
        bus.man_sel    = 2'(sel);
        tick();
        tick();
        bus.agc_en = 1'b1;
        tick();
        mdl_m    = man;
        mdl_sel  = sel;
        mdl_unch = 0;
    endtask

    function automatic logic [18:0] gain_inc(input int m, input int sel, input int amt);
        int n = m + amt;
        if (n <= GMAX) return {2'(sel), 17'(n)};
        if (sel < 3) return {2'(sel + 1), 17'(n / 2)};
        return {2'(sel), 17'(GMAX)};
    endfunction

    function automatic logic [18:0] gain_dec(input int m, input int sel, input int amt);
        int n = m - amt;
        int v;
        if (n >= GMIN) return {2'(sel), 17'(n)};
        if (sel == 0) return {2'd0, 17'(GMIN)};
        v = (n < 0) ? 0 : n * 2;
        if (v < GMIN) v = GMIN;
        if (v > GMAX) v = GMAX;
        return {2'(sel - 1), 17'(v)};
    endfunction

    task automatic model_window(input int mean, input int clips);
        int hi, lo;
        logic [18:0] g;
        logic cl, chg;
        hi = int'(bus.target) + int'(bus.hyst);
        lo = (bus.target > bus.hyst) ? int'(bus.target) - int'(bus.hyst) : 0;
        g  = {2'(mdl_sel), 17'(mdl_m)};
        cl = 1'b0;
        if (clips >= int'(bus.clip_thr)) begin
            cl = 1'b1;
            g  = gain_dec(mdl_m, mdl_sel, 4 * int'(bus.step));
        end else if (mean > hi) begin
            g = gain_dec(mdl_m, mdl_sel, int'(bus.step));
        end else if (mean < lo) begin
            g = gain_inc(mdl_m, mdl_sel, int'(bus.step));
        end
        chg      = (int'(g[16:0]) != mdl_m) || (int'(g[18:17]) != mdl_sel);
        mdl_unch = chg ? 0 : mdl_unch + 1;
        mdl_m    = int'(g[16:0]);
        mdl_sel  = int'(g[18:17]);
        exp_q.push_back({(mdl_unch >= 4), cl, chg, g});
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // mode 0: fixed I=a Q=b; mode 1: |I|+|Q|=a with random split/signs; mode 2: uniform in [-a,a] with valid gaps
    task automatic run_window(input int mode, input int a, input int b, input bit junk_upd, input bit stop);
        int sum = 0;
        int clips = 0;
        int vi, vq, x;
        logic [21:0] e;
        for (int k = 0; k < WIN; k++) begin
            if (mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.data_valid = 1'b0;
                    tick();
                end
            end
            if (mode == 0) begin
                vi = a;
                vq = b;
            end else if (mode == 1) begin
                x  = $urandom_range(0, a);
                vi = ($urandom_range(0, 1) == 1) ? x : -x;
                vq = ($urandom_range(0, 1) == 1) ? (a - x) : -(a - x);
            end else begin
                vi = int'($urandom_range(0, 2 * a)) - a;
                vq = int'($urandom_range(0, 2 * a)) - a;
            end
            bus.data_i     = 15'(vi);
            bus.data_q     = 15'(vq);
            bus.data_valid = 1'b1;
            sum += iabs(vi) + iabs(vq);
            if (vi == 16383 || vi == -16384 || vq == 16383 || vq == -16384) clips++;
            tick();
        end
        model_window(sum / WIN, clips);
        if (junk_upd) begin
            bus.data_i = 15'sd12000;
            bus.data_q = 15'sd12000;
        end else begin
            bus.data_valid = 1'b0;
        end
        tick();
        bus.data_valid = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bus.update !== e[19]) begin errors++; $display("FAIL win_update: got %b required %b", bus.update, e[19]); end
        checks++; if (bus.ddc_agc_value !== e[16:0]) begin errors++; $display("FAIL win_value: got %h required %h", bus.ddc_agc_value, e[16:0]); end
        checks++; if (bus.ddc_agc_6db_sel !== e[18:17]) begin errors++; $display("FAIL win_sel: got %0d required %0d", bus.ddc_agc_6db_sel, e[18:17]); end
        checks++; if (bus.clip !== e[20]) begin errors++; $display("FAIL win_clip: got %b required %b", bus.clip, e[20]); end
        checks++; if (bus.locked !== e[21]) begin errors++; $display("FAIL win_locked: got %b required %b", bus.locked, e[21]); end
        if (stop) return;
        if (e[19]) begin
            bus.data_i     = 15'sd12000;
            bus.data_q     = 15'sd12000;
            bus.data_valid = 1'b1;
            tick();
            checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL update_pulse_width: got %b required 0", bus.update); end
            repeat (6) tick();
            checks++; if (bus.fsm_state !== S_HOLD) begin errors++; $display("FAIL hold_len_7: got %0d required %0d", bus.fsm_state, S_HOLD); end
            tick();
            bus.data_valid = 1'b0;
            checks++; if (bus.fsm_state !== S_ACC) begin errors++; $display("FAIL hold_len_8: got %0d required %0d", bus.fsm_state, S_ACC); end
        end else begin
            checks++; if (bus.fsm_state !== S_ACC) begin errors++; $display("FAIL upd_to_acc: got %0d required %0d", bus.fsm_state, S_ACC); end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.agc_en = 1'b1;
        repeat (3) tick();
        checks++; if (bus.ddc_agc_value !== 17'h08000) begin errors++; $display("FAIL reset_value: got %h required 08000", bus.ddc_agc_value); end
        checks++; if (bus.ddc_agc_6db_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d required 0", bus.ddc_agc_6db_sel); end
        checks++; if ({bus.update, bus.locked, bus.clip} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b required 000", {bus.update, bus.locked, bus.clip}); end
        checks++; if (bus.fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d required 0", bus.fsm_state); end
        bus.agc_en = 1'b0;
        rst_n      = 1'b1;
        tick();
    endtask

    task automatic test_manual();
        bus.agc_en    = 1'b0;
        bus.man_value = 17'h1ABCD;
        bus.man_sel   = 2'd2;
        tick();
        checks++; if (bus.ddc_agc_value !== 17'h1ABCD) begin errors++; $display("FAIL manual_value: got %h required 1abcd", bus.ddc_agc_value); end
        checks++; if (bus.ddc_agc_6db_sel !== 2'd2) begin errors++; $display("FAIL manual_sel: got %0d required 2", bus.ddc_agc_6db_sel); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL manual_locked: got %b required 0", bus.locked); end
    endtask

    task automatic test_increase();
        set_cfg(4000, 100, 'h100, 3);
        enable_loop('h8000, 0);
        run_window(0, 1000, 1000, 1'b0, 1'b0);
        checks++; if (bus.ddc_agc_value !== 17'h08100) begin errors++; $display("FAIL increase_value: got %h required 08100", bus.ddc_agc_value); end
    endtask

    task automatic test_coarse_wrap();
        enable_loop('hFF80, 0);
        run_window(0, 1000, 1000, 1'b0, 1'b0);
        checks++; if ({bus.ddc_agc_6db_sel, bus.ddc_agc_value} !== {2'd1, 17'h08040}) begin errors++; $display("FAIL wrap_up: got %0d/%h required 1/08040", bus.ddc_agc_6db_sel, bus.ddc_agc_value); end
        enable_loop('hFF80, 3);
        run_window(0, 1000, 1000, 1'b0, 1'b0);
        checks++; if ({bus.ddc_agc_6db_sel, bus.ddc_agc_value} !== {2'd3, 17'h0FFFF}) begin errors++; $display("FAIL wrap_top: got %0d/%h required 3/0ffff", bus.ddc_agc_6db_sel, bus.ddc_agc_value); end
    endtask

    task automatic test_fast_attack();
        set_cfg(4000, 100, 'h100, 3);
        enable_loop('hA000, 0);
        run_window(0, 16383, 0, 1'b0, 1'b0);
        checks++; if ({bus.clip, bus.ddc_agc_value} !== {1'b1, 17'h09C00}) begin errors++; $display("FAIL fast_attack: got clip %b value %h required clip 1 value 09c00", bus.clip, bus.ddc_agc_value); end
    endtask

    task automatic test_decrease();
        set_cfg(4000, 100, 'h100, 'hFFFF);
        enable_loop('hA000, 0);
        run_window(0, -16384, 0, 1'b0, 1'b0);
        checks++; if (bus.ddc_agc_value !== 17'h09F00) begin errors++; $display("FAIL decrease_value: got %h required 09f00", bus.ddc_agc_value); end
        enable_loop('h8040, 1);
        run_window(0, 12000, 12000, 1'b0, 1'b0);
        checks++; if ({bus.ddc_agc_6db_sel, bus.ddc_agc_value} !== {2'd0, 17'h0FE80}) begin errors++; $display("FAIL wrap_down: got %0d/%h required 0/0fe80", bus.ddc_agc_6db_sel, bus.ddc_agc_value); end
    endtask

    task automatic test_deadband();
        set_cfg(4000, 100, 'h100, 3);
        enable_loop('h9000, 1);
        repeat (4) run_window(1, 4000, 0, 1'b1, 1'b0);
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL deadband_locked: got %b required 1", bus.locked); end
        run_window(0, 1000, 1000, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        set_cfg(4000, 100, 'h100, 'hFFFF);
        enable_loop('h9000, 1);
        bus.data_i     = 15'sd12000;
        bus.data_q     = 15'sd12000;
        bus.data_valid = 1'b1;
        repeat (6) tick();
        bus.man_value = 17'h0C123;
        bus.man_sel   = 2'd2;
        bus.agc_en    = 1'b0;
        tick();
        checks++; if (bus.fsm_state !== S_IDLE) begin errors++; $display("FAIL abort_state: got %0d required 0", bus.fsm_state); end
        checks++; if (bus.ddc_agc_value !== 17'h09000) begin errors++; $display("FAIL abort_value_1st: got %h required 09000", bus.ddc_agc_value); end
        tick();
        bus.data_valid = 1'b0;
        checks++; if ({bus.ddc_agc_6db_sel, bus.ddc_agc_value} !== {2'd2, 17'h0C123}) begin errors++; $display("FAIL abort_value_2nd: got %0d/%h required 2/0c123", bus.ddc_agc_6db_sel, bus.ddc_agc_value); end
        enable_loop('h9000, 1);
        run_window(0, 1000, 1000, 1'b0, 1'b0);
        // reset landing inside HOLD
        enable_loop('h9000, 1);
        run_window(0, 1000, 1000, 1'b0, 1'b1);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        checks++; if ({bus.ddc_agc_6db_sel, bus.ddc_agc_value} !== {2'd0, 17'h08000}) begin errors++; $display("FAIL hold_reset_value: got %0d/%h required 0/08000", bus.ddc_agc_6db_sel, bus.ddc_agc_value); end
        checks++; if (bus.fsm_state !== S_IDLE) begin errors++; $display("FAIL hold_reset_state: got %0d required 0", bus.fsm_state); end
        bus.agc_en = 1'b0;
        rst_n      = 1'b1;
        repeat (4) tick();
        checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL hold_reset_update: got %b required 0", bus.update); end
    endtask

    task automatic test_back_to_back();
        set_cfg(2000, 200, 'h80, 'hFFFF);
        enable_loop('hC000, 2);
        repeat (6) run_window(2, int'($urandom_range(500, 3000)), 0, 1'b1, 1'b0);
    endtask

    initial begin
        bus.agc_en     = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_i     = '0;
        bus.data_q     = '0;
        bus.man_value  = 17'h08000;
        bus.man_sel    = 2'd0;
        set_cfg(4000, 100, 'h100, 3);
        test_reset();
        test_manual();
        test_increase();
        test_coarse_wrap();
        test_fast_attack();
        test_decrease();
        test_deadband();
        test_abort();
        test_back_to_back();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries required 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ddc_agc_ctrl.md
DDC_AGC_CTRL -- requirements
Module: ddc_agc_ctrl

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 10: averaging window of 2^WIN_LOG2 valid samples, legal range 2..16.
REQ-002 SHALL have parameter SETTLE, default 8: clock cycles ignored after each gain update.
REQ-003 SHALL have parameters GAIN_MIN, default 17'h08000, and GAIN_MAX, default 17'h0FFFF: the fine gain bounds.
REQ-004 ddc_agc_ctrl_clk  in  1  single clock; all logic on the rising edge.
REQ-005 ddc_agc_ctrl_rst_n  in  1  reset; synchronous, active-low.
REQ-006 agc_en  in  1  1 = closed loop; 0 = manual gain.
REQ-007 data_valid  in  1  qualifies data_i and data_q.
REQ-008 data_i, data_q  in  15 signed  AGC output samples fed back.
REQ-009 target, hyst  in  16 unsigned  target mean magnitude and deadband half-width.
REQ-010 step  in  16 unsigned  fine gain step per window.
REQ-011 clip_thr  in  16 unsigned  clip count that triggers fast attack.
REQ-012 man_value  in  17; man_sel  in  2  manual gain.
REQ-013 ddc_agc_value  out  17  fine gain to the multiplier.
REQ-014 ddc_agc_6db_sel  out  2  coarse 6 dB shift select.
REQ-015 update  out  1  one-cycle pulse when the gain changes.
REQ-016 locked  out  1  gain stable.
REQ-017 clip  out  1  last window hit the clip threshold.

Function
REQ-018 The FSM SHALL have states IDLE, ACC, UPD and HOLD.
REQ-019 IDLE: while agc_en=0, outputs SHALL be registered man_value/man_sel, locked=0, and the accumulators cleared.
REQ-020 agc_en=1 in IDLE SHALL load the current man_value/man_sel as the loop gain and enter ACC.
REQ-021 ACC: each valid sample SHALL add |I|+|Q|, 16-bit, to a 32-bit accumulator, with |-16384|=16384.
REQ-022 ACC: a sample SHALL count as clipped when I or Q equals +16383 or -16384.
REQ-023 ACC SHALL go to UPD in the cycle after the 2^WIN_LOG2-th valid sample is accumulated.
REQ-024 UPD (one cycle): mean SHALL be acc>>WIN_LOG2, 16 bits.
REQ-025 UPD: if clip count >= clip_thr, the gain SHALL decrease by step<<2 and clip=1; otherwise clip=0.
REQ-026 UPD, no clip: mean > target+hyst SHALL decrease the gain by step.
REQ-027 UPD, no clip: mean < target-hyst SHALL increase the gain by step.
REQ-028 UPD, no clip: otherwise the gain SHALL be unchanged; target±hyst is computed in 17 bits, target-hyst floored at 0.
REQ-029 Increase SHALL compute new=m+step in 18 bits; if new > GAIN_MAX and sel<3, then sel+1 and m=new>>1; if new > GAIN_MAX and sel=3, then m=GAIN_MAX.
REQ-030 Decrease SHALL compute new=m-step as 18-bit signed; if new < GAIN_MIN and sel>0, then sel-1 and m=clamp(max(new,0)<<1, GAIN_MIN, GAIN_MAX); if new < GAIN_MIN and sel=0, then m=GAIN_MIN.
REQ-031 update SHALL pulse in the cycle after UPD only if m or sel changed.
REQ-032 On a change, UPD SHALL go to HOLD; with no change, it SHALL go directly to ACC.
REQ-033 HOLD SHALL wait SETTLE clocks to flush the downstream pipeline, ignore samples, then clear the accumulators and enter ACC.
REQ-034 locked SHALL set after 4 consecutive unchanged windows and clear in the same cycle as any update pulse.
REQ-035 agc_en falling in any state SHALL enter IDLE next cycle, discarding the partial window, with manual outputs on the following cycle.
REQ-036 A data_valid sample coinciding with the ACC->UPD transition SHALL be dropped; no sample SHALL be counted twice.

Reset
REQ-037 With rst_n=0 at a clock edge, the next state SHALL be IDLE.
REQ-038 During reset, ddc_agc_value SHALL be 17'h08000, ddc_agc_6db_sel 0, and update, locked, clip 0.
REQ-039 During reset, the accumulators and counters SHALL be cleared.
REQ-040 Reset SHALL override agc_en, including mid-window or mid-HOLD.

Verification (WIN_LOG2=4, SETTLE=8)
REQ-041 Reset: hold rst_n=0 for 3 clocks -> value 08000, sel 0, update/locked/clip 0.
REQ-042 Increase: man 08000/0, I=Q=1000 for 16 samples, target 4000, hyst 100, step 0x100 -> mean 2000, value 08100, one update pulse, then HOLD 8 clocks.
REQ-043 Coarse wrap: m=0FF80, sel 0, increase by 0x100 -> sel 1, value 08040; repeat at sel 3 -> value 0FFFF, sel stays 3.
REQ-044 Fast attack: I=16383 on all samples, clip_thr 3, m=0A000 -> value 09C00, clip=1.
REQ-045 Deadband: mean within target±hyst for 4 windows -> no update, locked=1 after the 4th UPD.
REQ-046 Abort: agc_en=0 at sample 7 -> manual value on the 2nd clock; rst_n=0 during HOLD -> reset values, no update.
